// File: rtl/fifo_ctr.sv
// rtl/fifo_ctr.sv - first-word-fall-through FIFO controller with occupancy flags
// Circular buffer of any depth, pass-through on full, sticky overflow/underflow.
module fifo_ctr #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 3,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  enq_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  deq_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o_n,
  output logic                  empty_o_n,
  output logic [CW-1:0]         count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic is_empty, is_full;
  logic enq_ok, deq_ok;

  assign is_empty = (count_q == '0);
  assign is_full  = (int'(count_q) == FIFO_DEPTH);

  // A flush cycle swallows both requests; a pop frees room for a same-cycle push when full.
  assign deq_ok = deq_i & ~is_empty & ~clr_i;
  assign enq_ok = enq_i & (~is_full | deq_ok) & ~clr_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (deq_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (enq_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (enq_i && !enq_ok) begin
        overflow_d = 1'b1;
      end
      if (deq_i && is_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk_i) begin
    if (enq_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o         = is_empty ? '0 : mem_q[rd_ptr_q];
  assign full_o_n       = ~is_full;
  assign empty_o_n      = ~is_empty;
  assign count_o        = count_q;
  assign almost_full_o  = (int'(count_q) >= AFULL_THRESH);
  assign almost_empty_o = (int'(count_q) <= AEMPTY_THRESH);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_ctr.sv
// tb/tb_fifo_ctr.sv - directed and randomized checks of fifo_ctr against a queue model
module tb_fifo_ctr;

  localparam int DW    = 16;
  localparam int DEPTH = 3;
  localparam int AF    = 2;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          enq = 1'b0;
  logic [DW-1:0] din = '0;
  logic          deq = 1'b0;
  logic [DW-1:0] dout;
  logic          full_n, empty_n, afull, aempty, ovf, unf;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;

  fifo_ctr #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clr_i         (clr),
    .enq_i         (enq),
    .din_i         (din),
    .deq_i         (deq),
    .dout_o        (dout),
    .full_o_n      (full_n),
    .empty_o_n     (empty_n),
    .count_o       (count),
    .almost_full_o (afull),
    .almost_empty_o(aempty),
    .overflow_o    (ovf),
    .underflow_o   (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},   32'(count),   32'(n));
    chk({tag, ".full_n"},  32'(full_n),  32'(n != DEPTH));
    chk({tag, ".empty_n"}, 32'(empty_n), 32'(n != 0));
    chk({tag, ".dout"},    32'(dout),    (n != 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".afull"},   32'(afull),   32'(n >= AF));
    chk({tag, ".aempty"},  32'(aempty),  32'(n <= AE));
    chk({tag, ".ovf"},     32'(ovf),     32'(m_ovf));
    chk({tag, ".unf"},     32'(unf),     32'(m_unf));
  endtask

  // Reference behaviour from the occupancy rules, applied to the pre-edge model state.
  task automatic model_edge(input bit e, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_empty, was_full, r_ok, e_ok;
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    r_ok = r && !was_empty;
    e_ok = e && (!was_full || r_ok);
    if (r && was_empty) m_unf = 1;
    if (e && !e_ok) m_ovf = 1;
    if (r_ok) void'(q.pop_front());
    if (e_ok) q.push_back(d);
  endtask

  task automatic step(input string tag, input bit e, input logic [DW-1:0] d, input bit r, input bit c);
    enq = e;
    din = d;
    deq = r;
    clr = c;
    @(posedge clk);
    #1;
    model_edge(e, d, r, c);
    enq = 0;
    deq = 0;
    clr = 0;
    din = '0;
    check_all(tag);
  endtask

  initial begin
    #3;
    check_all("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_post");

    step("fill1", 1, 16'hA1, 0, 0);
    chk("fill1.dout_const", 32'(dout), 32'hA1);
    step("fill2", 1, 16'hA2, 0, 0);
    chk("fill2.afull_const", 32'(afull), 32'd1);
    step("fill3", 1, 16'hA3, 0, 0);
    chk("fill3.full_n_const", 32'(full_n), 32'd0);
    chk("fill3.dout_const", 32'(dout), 32'hA1);

    step("ovf", 1, 16'hFF, 0, 0);
    chk("ovf.flag_const", 32'(ovf), 32'd1);
    step("ovf_drain1", 0, 0, 1, 0);
    chk("ovf_drain1.dout_const", 32'(dout), 32'hA2);
    step("ovf_drain2", 0, 0, 1, 0);
    step("ovf_drain3", 0, 0, 1, 0);
    chk("ovf_drain3.dout_const", 32'(dout), 32'h0);

    step("clr_flags", 0, 0, 0, 1);
    step("pt_fill1", 1, 16'hA1, 0, 0);
    step("pt_fill2", 1, 16'hA2, 0, 0);
    step("pt_fill3", 1, 16'hA3, 0, 0);
    step("pt_both", 1, 16'hB4, 1, 0);
    chk("pt_both.dout_const", 32'(dout), 32'hA2);
    chk("pt_both.count_const", 32'(count), 32'd3);
    chk("pt_both.ovf_const", 32'(ovf), 32'd0);
    step("pt_drain1", 0, 0, 1, 0);
    chk("pt_drain1.dout_const", 32'(dout), 32'hA3);
    step("pt_drain2", 0, 0, 1, 0);
    chk("pt_drain2.dout_const", 32'(dout), 32'hB4);
    step("pt_drain3", 0, 0, 1, 0);

    step("unf_deq", 0, 0, 1, 0);
    chk("unf_deq.flag_const", 32'(unf), 32'd1);
    step("unf_enqdeq", 1, 16'hC5, 1, 0);
    chk("unf_enqdeq.dout_const", 32'(dout), 32'hC5);
    step("unf_pop", 0, 0, 1, 0);
    step("unf_push", 1, 16'hC6, 0, 0);
    chk("unf_push.dout_const", 32'(dout), 32'hC6);

    step("cl_fill2", 1, 16'h11, 0, 0);
    step("cl_fill3", 1, 16'h12, 0, 0);
    step("cl_ovf", 1, 16'h13, 0, 0);
    step("cl_pop", 0, 0, 1, 0);
    chk("cl_pop.count_const", 32'(count), 32'd2);
    step("cl_clr", 1, 16'h14, 1, 1);
    chk("cl_clr.count_const", 32'(count), 32'd0);
    chk("cl_clr.ovf_const", 32'(ovf), 32'd0);

    step("ar_fill1", 1, 16'h21, 0, 0);
    step("ar_fill2", 1, 16'h22, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_all("ar_async");
    chk("ar_async.aempty_const", 32'(aempty), 32'd1);
    #2;
    rst_n = 1'b1;
    step("ar_enq", 1, 16'hD6, 0, 0);
    chk("ar_enq.dout_const", 32'(dout), 32'hD6);

    for (int i = 0; i < 500; i++) begin
      step("rand", ($urandom_range(0, 99) < 55), DW'($urandom),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctr.md
FIFO_CTR -- requirements
Module: fifo_ctr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 3, number of entries (>=1, need not be a power of two).
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-1, count at or above which almost_full_o asserts.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1, count at or below which almost_empty_o asserts.
REQ-005 SHALL define CW = $clog2(FIFO_DEPTH+1) as the count width.
REQ-006 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-008 clr_i  input  1  synchronous flush.
REQ-009 enq_i  input  1  enqueue request.
REQ-010 din_i  input  DATA_WIDTH  enqueue data.
REQ-011 deq_i  input  1  dequeue request.
REQ-012 dout_o  output  DATA_WIDTH  head entry (first-word-fall-through).
REQ-013 full_o_n  output  1  low when count == FIFO_DEPTH.
REQ-014 empty_o_n  output  1  low when count == 0.
REQ-015 count_o  output  CW  current occupancy.
REQ-016 almost_full_o / almost_empty_o  output  1 each  threshold flags.
REQ-017 overflow_o / underflow_o  output  1 each  sticky error flags.

Function
REQ-018 SHALL store entries in a circular buffer; read and write pointers wrap from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH.
REQ-019 Enqueue accepted when enq_i=1 and (full_o_n=1 or deq_i=1 with empty_o_n=1); din_i written at write pointer.
REQ-020 Dequeue accepted when deq_i=1 and empty_o_n=1; read pointer advances.
REQ-021 Simultaneous accepted enq and deq SHALL leave count unchanged, including when full (pass-through-on-full) .
REQ-022 enq_i=1 while full without accepted deq SHALL be dropped, storage untouched, overflow_o set.
REQ-023 deq_i=1 while empty SHALL be ignored and set underflow_o; a same-cycle enq into empty is still accepted.
REQ-024 Overflow/underflow flags SHALL stay 1 until clr_i or reset.
REQ-025 dout_o SHALL equal entry at read pointer whenever empty_o_n=1, and all-zero when empty_o_n=0.
REQ-026 Latency: data enqueued at edge N visible on dout_o and empty_o_n=1 after edge N (0 cycles added); dequeue at edge N presents next entry after edge N.
REQ-027 count_o, full_o_n, empty_o_n, almost flags SHALL be derived from the registered count and change only after a clock edge.
REQ-028 almost_full_o = (count_o >= AFULL_THRESH); almost_empty_o = (count_o <= AEMPTY_THRESH).
REQ-029 clr_i=1 SHALL, at next edge, zero pointers, count and both sticky flags; enq_i/deq_i that cycle SHALL be ignored and not flagged.
REQ-030 Count arithmetic SHALL be CW bits and never exceed FIFO_DEPTH nor go below 0.

Reset
REQ-031 rst_n_i=0 SHALL asynchronously zero pointers, count, overflow_o, underflow_o; storage array is not reset.
REQ-032 During and after reset: empty_o_n=0, full_o_n=1, count_o=0, dout_o=0, almost_empty_o=1, almost_full_o=0 (when AFULL_THRESH>0).
REQ-033 Reset asserted mid-operation SHALL discard all contents; first post-reset enqueue appears at dout_o.

Verification (DATA_WIDTH=16, FIFO_DEPTH=3, AFULL_THRESH=2, AEMPTY_THRESH=1)
REQ-034 Fill: enq 0xA1,0xA2,0xA3 on 3 edges -> count 1,2,3; almost_full at count 2; full_o_n=0 at 3; dout_o=0xA1 throughout.
REQ-035 Overflow: at full, enq 0xFF without deq -> count 3, overflow_o=1, drain yields 0xA1,0xA2,0xA3 then empty_o_n=0, dout_o=0.
REQ-036 Full pass-through: at full {A1,A2,A3}, enq 0xB4 + deq same edge -> count 3, dout_o=0xA2; drain yields A2,A3,B4 (checks wrap).
REQ-037 Underflow: deq on empty -> underflow_o=1, count 0; deq+enq 0xC5 on empty -> count 1, dout_o=0xC5, no pointer move on read.
REQ-038 Clear: count 2 with overflow_o=1, assert clr_i with enq_i=1 -> next edge count 0, flags 0, empty_o_n=0.
REQ-039 Async reset: drop rst_n_i between edges with count 2 -> outputs take REQ-032 values before next edge; enq 0xD6 after release -> dout_o=0xD6.
